// File: rtl/latch_sampler_pkg.sv
// Shared types and default constants for the latch_sampler block.
package latch_sampler_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Sampler FSM: wait for an open phase, wait for close, let the latch
  // output settle, then take one sample.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/latch_sampler_if.sv
// Bundle of the upstream latch signals and the downstream valid/ready port.
// master = sampler side, slave = latch/consumer side.
interface latch_sampler_if
  import latch_sampler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             lat_en;
  logic [WIDTH-1:0] lat_q;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    input  lat_en,
    input  lat_q,
    input  out_ready,
    input  ovr_clr,
    output out_data,
    output out_valid,
    output overrun
  );

  modport slave (
    output lat_en,
    output lat_q,
    output out_ready,
    output ovr_clr,
    input  out_data,
    input  out_valid,
    input  overrun
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchronizer, async active-high reset to 0.
module sync_ff
  import latch_sampler_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/latch_sampler.sv
// latch_sampler: brings the value held by a level-sensitive latch into the
// clk domain once the latch has closed and stayed closed long enough.
// Optional build macro LATCH_SAMPLER_STABLE_CHECK_EN: also require lat_q to
// read identically on consecutive SETTLE cycles before capturing.
module latch_sampler
  import latch_sampler_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  latch_sampler_if.master bus
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             en_s;
  logic             en_d_q;
  logic             fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap;
  logic [WIDTH-1:0] cap_src;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.lat_en),
    .q_o (en_s)
  );

  // One-cycle delay of the synchronized enable for close detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d_q <= 1'b0;
    end else begin
      en_d_q <= en_s;
    end
  end

  assign fall = en_d_q & ~en_s;

`ifdef LATCH_SAMPLER_STABLE_CHECK_EN
  logic [WIDTH-1:0] samp_q, samp_d;

  // Registered copy of lat_q used both for the stability compare and as
  // the captured value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
    end else begin
      samp_q <= samp_d;
    end
  end

  assign cap_src = samp_q;
`else
  assign cap_src = bus.lat_q;
`endif

  // FSM and settle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: open phase must be seen, then a quiet close of
  // SETTLE_CYCLES before the single capture cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
`ifdef LATCH_SAMPLER_STABLE_CHECK_EN
    samp_d  = samp_q;
`endif
    case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (fall) begin
          state_d = SETTLE;
          cnt_d   = '0;
`ifdef LATCH_SAMPLER_STABLE_CHECK_EN
          samp_d  = bus.lat_q;
`endif
        end
      end
      SETTLE: begin
`ifdef LATCH_SAMPLER_STABLE_CHECK_EN
        samp_d = bus.lat_q;
`endif
        if (en_s) begin
          // Latch reopened before the value was trusted: no capture.
          state_d = OPEN;
          cnt_d   = '0;
`ifdef LATCH_SAMPLER_STABLE_CHECK_EN
        end else if (bus.lat_q != samp_q) begin
          // Output still moving: restart the quiet-time count.
          cnt_d = '0;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CAPTURE: begin
        cap     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register next-state: accept a capture if the slot is free or
  // being emptied this cycle, otherwise flag the drop. Set beats clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (bus.ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (cap) begin
      if (!valid_q || bus.out_ready) begin
        data_d  = cap_src;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output word, valid flag and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_latch_sampler.sv
// Scoreboard bench for latch_sampler (default parameters). The stable-data
// scenario is included only when LATCH_SAMPLER_STABLE_CHECK_EN is defined.
module tb_latch_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  latch_sampler_if #(.WIDTH(8)) bus ();

  latch_sampler #(
    .WIDTH         (8),
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Open the latch with word d, then close it and wait 'low' edges.
  task automatic open_close(input logic [7:0] d, input int low);
    bus.lat_en = 1'b1;
    bus.lat_q  = d;
    tick(4);
    bus.lat_en = 1'b0;
    tick(low);
  endtask

  // Scoreboard: every handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        chk("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.lat_en    = 1'b0;
    bus.lat_q     = 8'h00;
    bus.out_ready = 1'b0;
    bus.ovr_clr   = 1'b0;
    tick(3);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    rst = 1'b0;

    // Basic capture and latency.
    bus.lat_en = 1'b1;
    bus.lat_q  = 8'hA5;
    tick(4);
    bus.lat_en = 1'b0;
    exp_q.push_back(8'hA5);
    tick(5);
    chk("lat_edge5_valid", 32'(bus.out_valid), 32'd0);
    tick(1);
    chk("lat_edge6_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_edge6_data", 32'(bus.out_data), 32'hA5);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk("pop_clears_valid", 32'(bus.out_valid), 32'd0);

    // Short close: aborted, nothing captured.
    bus.lat_en = 1'b1;
    bus.lat_q  = 8'h5C;
    tick(4);
    bus.lat_en = 1'b0;
    tick(2);
    bus.lat_en = 1'b1;
    tick(8);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);

    // Overrun: second word dropped while first is unconsumed.
    exp_q.push_back(8'h11);
    open_close(8'h11, 8);
    chk("ovr_first_valid", 32'(bus.out_valid), 32'd1);
    chk("ovr_first_data", 32'(bus.out_data), 32'h11);
    chk("ovr_first_flag", 32'(bus.overrun), 32'd0);
    open_close(8'h22, 8);
    chk("ovr_keep_data", 32'(bus.out_data), 32'h11);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    bus.ovr_clr = 1'b1;
    tick(1);
    bus.ovr_clr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'd0);

    // Capture coincides with a handshake on the old word.
    open_close(8'h22, 5);
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h22);
    tick(1);
    bus.out_ready = 1'b0;
    chk("same_cyc_valid", 32'(bus.out_valid), 32'd1);
    chk("same_cyc_data", 32'(bus.out_data), 32'h22);
    chk("same_cyc_ovr", 32'(bus.overrun), 32'd0);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of SETTLE with a word pending and overrun set.
    open_close(8'h77, 8);
    open_close(8'h5A, 8);
    chk("pre_rst_ovr", 32'(bus.overrun), 32'd1);
    open_close(8'hC3, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_data", 32'(bus.out_data), 32'd0);
    chk("async_rst_ovr", 32'(bus.overrun), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("no_cap_after_rst", 32'(bus.out_valid), 32'd0);
    exp_q.push_back(8'hC3);
    open_close(8'hC3, 6);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;

`ifdef LATCH_SAMPLER_STABLE_CHECK_EN
    // Data changes one cycle into SETTLE: quiet-time count restarts.
    exp_q.push_back(8'h44);
    open_close(8'h33, 3);
    bus.lat_q = 8'h44;
    tick(3);
    chk("stab_delayed", 32'(bus.out_valid), 32'd0);
    tick(1);
    chk("stab_valid", 32'(bus.out_valid), 32'd1);
    chk("stab_data", 32'(bus.out_data), 32'h44);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
`endif

    tick(2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
